// File: rtl/pc_sequencer_if.sv
// rtl/pc_sequencer_if.sv - decoder-to-PC-sequencer control and status bundle
interface pc_sequencer_if #(
  parameter int PC_WIDTH     = 12,
  parameter int OFFSET_WIDTH = 8,
  parameter int STACK_DEPTH  = 8
);
  localparam int SD_W = $clog2(STACK_DEPTH) + 1;

  // Control from the decoder
  logic                    stall;
  logic                    sel_pc_plus1;
  logic                    sel_pc_offset;
  logic                    sel_pc_const;
  logic                    call;
  logic                    ret;
  logic [1:0]              cond;
  logic                    flag_z;
  logic                    flag_c;
  logic [OFFSET_WIDTH-1:0] offset;
  logic [PC_WIDTH-1:0]     target;

  // Status back from the sequencer
  logic [PC_WIDTH-1:0]     pc;
  logic [PC_WIDTH-1:0]     pc_plus1;
  logic                    branch_taken;
  logic [SD_W-1:0]         stack_depth;
  logic                    stack_overflow;
  logic                    stack_underflow;

  // Decoder side: drives selects and operands, observes the PC
  modport master (
    output stall, sel_pc_plus1, sel_pc_offset, sel_pc_const, call, ret,
           cond, flag_z, flag_c, offset, target,
    input  pc, pc_plus1, branch_taken, stack_depth, stack_overflow,
           stack_underflow
  );

  // Sequencer side
  modport slave (
    input  stall, sel_pc_plus1, sel_pc_offset, sel_pc_const, call, ret,
           cond, flag_z, flag_c, offset, target,
    output pc, pc_plus1, branch_taken, stack_depth, stack_overflow,
           stack_underflow
  );
endinterface

// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - program counter with branch/jump select and return-address stack
module pc_sequencer #(
  parameter int PC_WIDTH     = 12,
  parameter int OFFSET_WIDTH = 8,
  parameter int STACK_DEPTH  = 8
) (
  input  logic         clk,
  input  logic         rst,
  pc_sequencer_if.slave bus
);
  localparam int PTR_W = $clog2(STACK_DEPTH);

  logic [PC_WIDTH-1:0] r_pc;
  logic [PTR_W:0]      r_depth;
  logic                r_overflow;
  logic                r_underflow;
  logic [PC_WIDTH-1:0] r_stack [STACK_DEPTH];

  logic [PC_WIDTH-1:0] w_pc_plus1;
  logic [PC_WIDTH-1:0] w_off_ext;
  logic [PC_WIDTH-1:0] w_branch_pc;
  logic [PC_WIDTH-1:0] w_next_pc;
  logic [PTR_W-1:0]    w_top_idx;
  logic [PTR_W-1:0]    w_wr_idx;
  logic                w_full;
  logic                w_empty;
  logic                w_cond_true;
  logic                w_redirect;
  logic                w_push;
  logic                w_pop;
  logic                w_set_ovf;
  logic                w_set_unf;

  assign w_pc_plus1  = r_pc + PC_WIDTH'(1);
  assign w_off_ext   = {{(PC_WIDTH-OFFSET_WIDTH){bus.offset[OFFSET_WIDTH-1]}}, bus.offset};
  assign w_branch_pc = w_pc_plus1 + w_off_ext;
  assign w_full      = (r_depth == (PTR_W+1)'(STACK_DEPTH));
  assign w_empty     = (r_depth == '0);
  // Top of stack sits one below the write pointer; write pointer is the depth itself
  assign w_top_idx   = PTR_W'(r_depth - 1'b1);
  assign w_wr_idx    = r_depth[PTR_W-1:0];

  // Branch condition decode against the upstream ALU flags
  always_comb begin
    w_cond_true = 1'b0;
    case (bus.cond)
      2'b00:   w_cond_true = bus.flag_z;
      2'b01:   w_cond_true = ~bus.flag_z;
      2'b10:   w_cond_true = bus.flag_c;
      default: w_cond_true = ~bus.flag_c;
    endcase
  end

  // Next-PC selection: ret > const > offset > fall-through
  always_comb begin
    w_next_pc  = w_pc_plus1;
    w_redirect = 1'b0;
    w_push     = 1'b0;
    w_pop      = 1'b0;
    w_set_ovf  = 1'b0;
    w_set_unf  = 1'b0;
    if (bus.ret) begin
      if (!w_empty) begin
        w_next_pc  = r_stack[w_top_idx];
        w_redirect = 1'b1;
        w_pop      = 1'b1;
      end else begin
        w_set_unf  = 1'b1;
      end
    end else if (bus.sel_pc_const) begin
      w_next_pc  = bus.target;
      w_redirect = 1'b1;
      if (bus.call) begin
        if (!w_full) w_push    = 1'b1;
        else         w_set_ovf = 1'b1;
      end
    end else if (bus.sel_pc_offset && w_cond_true) begin
      w_next_pc  = w_branch_pc;
      w_redirect = 1'b1;
    end
  end

  // PC, depth and sticky error flags; a stall freezes all of them
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc        <= '0;
      r_depth     <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else if (!bus.stall) begin
      r_pc <= w_next_pc;
      if (w_push)     r_depth <= r_depth + 1'b1;
      else if (w_pop) r_depth <= r_depth - 1'b1;
      if (w_set_ovf) r_overflow  <= 1'b1;
      if (w_set_unf) r_underflow <= 1'b1;
    end
  end

  // Return-address storage; contents need no reset since depth gates every read
  always_ff @(posedge clk) begin
    if (!rst && !bus.stall && w_push) begin
      r_stack[w_wr_idx] <= w_pc_plus1;
    end
  end

  assign bus.pc              = r_pc;
  assign bus.pc_plus1        = w_pc_plus1;
  assign bus.branch_taken    = w_redirect & ~bus.stall;
  assign bus.stack_depth     = r_depth;
  assign bus.stack_overflow  = r_overflow;
  assign bus.stack_underflow = r_underflow;
endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - scoreboard bench for pc_sequencer
module tb_pc_sequencer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pc_sequencer_if #(.PC_WIDTH(12), .OFFSET_WIDTH(8), .STACK_DEPTH(8)) bus ();

  pc_sequencer #(.PC_WIDTH(12), .OFFSET_WIDTH(8), .STACK_DEPTH(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    bit          chk;
    logic [11:0] pp;
    logic        bt;
  } comb_t;

  typedef struct {
    logic [11:0] pc;
    logic [3:0]  depth;
    logic        ovf;
    logic        unf;
  } st_t;

  comb_t qc[$];
  st_t   qs[$];

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  int m_pc = 0;
  int m_stk[$];
  bit m_ovf = 0;
  bit m_unf = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input bit r, input bit st, input bit p1, input bit po, input bit pk,
                       input bit cl, input bit rt, input logic [1:0] cd, input bit fz,
                       input bit fc, input logic [7:0] off, input logic [11:0] tgt);
    comb_t c;
    st_t   s;
    bit    ct;
    int    nxt;
    int    so;
    bit    tk;
    @(negedge clk);
    rst               = r;
    bus.stall         = st;
    bus.sel_pc_plus1  = p1;
    bus.sel_pc_offset = po;
    bus.sel_pc_const  = pk;
    bus.call          = cl;
    bus.ret           = rt;
    bus.cond          = cd;
    bus.flag_z        = fz;
    bus.flag_c        = fc;
    bus.offset        = off;
    bus.target        = tgt;

    c.chk = !r;
    c.pp  = 12'((m_pc + 1) % 4096);
    tk    = 0;
    nxt   = (m_pc + 1) % 4096;
    case (cd)
      2'd0:    ct = fz;
      2'd1:    ct = !fz;
      2'd2:    ct = fc;
      default: ct = !fc;
    endcase
    so = int'(off);
    if (off[7]) so -= 256;

    if (r) begin
      m_pc = 0;
      m_stk.delete();
      m_ovf = 0;
      m_unf = 0;
    end else if (!st) begin
      if (rt) begin
        if (m_stk.size() > 0) begin
          nxt = m_stk.pop_back();
          tk  = 1;
        end else begin
          m_unf = 1;
        end
      end else if (pk) begin
        nxt = int'(tgt);
        tk  = 1;
        if (cl) begin
          if (m_stk.size() < 8) m_stk.push_back((m_pc + 1) % 4096);
          else                  m_ovf = 1;
        end
      end else if (po && ct) begin
        nxt = (((m_pc + 1 + so) % 4096) + 4096) % 4096;
        tk  = 1;
      end
      m_pc = nxt;
    end
    c.bt = tk;
    qc.push_back(c);

    s.pc    = 12'(m_pc);
    s.depth = 4'(m_stk.size());
    s.ovf   = m_ovf;
    s.unf   = m_unf;
    qs.push_back(s);
  endtask

  task automatic nop();
    drive(0, 0, 0, 0, 0, 0, 0, 2'd0, 0, 0, 8'h00, 12'h000);
  endtask

  task automatic do_rst();
    drive(1, 0, 0, 0, 0, 0, 0, 2'd0, 0, 0, 8'h00, 12'h000);
  endtask

  task automatic jmp(input logic [11:0] t, input bit cl);
    drive(0, 0, 0, 0, 1, cl, 0, 2'd0, 0, 0, 8'h00, t);
  endtask

  task automatic br(input logic [1:0] cd, input bit fz, input bit fc, input logic [7:0] off);
    drive(0, 0, 0, 1, 0, 0, 0, cd, fz, fc, off, 12'h000);
  endtask

  task automatic rtn();
    drive(0, 0, 0, 0, 0, 0, 1, 2'd0, 0, 0, 8'h00, 12'h000);
  endtask

  // Combinational monitor: samples between the driving edge and the next rising edge
  initial begin
    comb_t c;
    forever begin
      @(negedge clk);
      #3;
      if (qc.size() > 0) begin
        c = qc.pop_front();
        if (c.chk) begin
          chk("branch_taken", 32'(bus.branch_taken), 32'(c.bt));
          chk("pc_plus1", 32'(bus.pc_plus1), 32'(c.pp));
        end
      end
    end
  end

  // Registered-state monitor: samples just after the rising edge
  initial begin
    st_t s;
    forever begin
      @(posedge clk);
      #1;
      if (qs.size() > 0) begin
        s = qs.pop_front();
        chk("pc", 32'(bus.pc), 32'(s.pc));
        chk("stack_depth", 32'(bus.stack_depth), 32'(s.depth));
        chk("stack_overflow", 32'(bus.stack_overflow), 32'(s.ovf));
        chk("stack_underflow", 32'(bus.stack_underflow), 32'(s.unf));
      end
    end
  end

  initial begin
    bus.stall = 0; bus.sel_pc_plus1 = 0; bus.sel_pc_offset = 0; bus.sel_pc_const = 0;
    bus.call = 0; bus.ret = 0; bus.cond = 2'd0; bus.flag_z = 0; bus.flag_c = 0;
    bus.offset = 8'h00; bus.target = 12'h000;

    do_rst();
    do_rst();
    repeat (5) nop();

    jmp(12'h00A, 0);
    br(2'd0, 1, 0, 8'hFB);
    jmp(12'h00A, 0);
    br(2'd0, 0, 0, 8'hFB);
    br(2'd1, 0, 0, 8'h10);
    br(2'd2, 0, 1, 8'h7F);
    br(2'd3, 0, 1, 8'h05);

    jmp(12'h000, 0);
    br(2'd0, 1, 0, 8'h80);
    jmp(12'hFFF, 0);
    drive(0, 0, 1, 0, 0, 0, 0, 2'd0, 0, 0, 8'h00, 12'h000);

    jmp(12'h010, 0);
    jmp(12'h100, 1);
    jmp(12'h200, 1);
    rtn();
    rtn();

    for (int i = 0; i < 9; i++) jmp(12'h300 + 12'(i * 16), 1);
    for (int i = 0; i < 9; i++) rtn();
    nop();

    do_rst();
    for (int i = 0; i < 3; i++) jmp(12'h400 + 12'(i), 1);
    do_rst();
    nop();

    for (int i = 0; i < 3; i++) jmp(12'h500 + 12'(i * 8), 1);
    drive(0, 1, 0, 0, 0, 0, 1, 2'd0, 0, 0, 8'h00, 12'h000);
    drive(0, 1, 1, 1, 1, 1, 0, 2'd0, 1, 0, 8'h20, 12'h123);
    rtn();
    drive(0, 0, 1, 1, 1, 1, 1, 2'd0, 1, 0, 8'h20, 12'h777);
    nop();

    for (int i = 0; i < 3000; i++) begin
      drive($urandom_range(0, 99) == 0, $urandom_range(0, 7) == 0,
            1'($urandom), 1'($urandom), $urandom_range(0, 3) == 0,
            1'($urandom), $urandom_range(0, 4) == 0,
            2'($urandom), 1'($urandom), 1'($urandom),
            8'($urandom_range(1, 255)), 12'($urandom));
    end

    repeat (3) @(posedge clk);
    #2;
    chk("scoreboard_drained", 32'(qs.size() + qc.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: run did not complete");
    $fatal(1);
  end
endmodule
